psram_pattern_tester: RTL
=========================

Name: psram_pattern_tester

Overview:
- Parametrised successor to the single-word PSRAM write/readback check in the top level.
- Writes a programmable pattern to a range of PSRAM words, then reads the range back and compares every word.
- Reports error count, first failing address and pass/fail.
- Drives the existing psram controller handshake (stb/we/addr/din/busy/dout) and feeds the on-screen status graph.

Parameters:
ADDR_W, 24, PSRAM word address width.
DATA_W, 16, data word width; legal values 8 or 16.
NUM_WORDS, 256, words per pass; must be >= 1.
START_ADDR, 0, first address of the pass.
ADDR_STEP, 1, address increment per word; addresses wrap modulo 2^ADDR_W.
ERR_W, 16, error counter width.

Ports:
clk_100mhz  in  1  system clock; all state changes on its rising edge.
rstn_i  in  1  reset, asynchronous, active-low.
i_start  in  1  one-cycle pulse that starts a pass; sampled in IDLE and DONE only.
i_mode  in  2  pattern select, latched at start: 0 constant, 1 address, 2 walking-one, 3 LFSR.
i_seed  in  DATA_W  constant value for mode 0 and LFSR seed for mode 3; latched at start.
o_stb  out  1  request strobe to the PSRAM controller.
o_we  out  1  write enable, qualified by o_stb.
o_addr  out  ADDR_W  request address.
o_din  out  DATA_W  write data.
i_busy  in  1  controller busy.
i_dout  in  DATA_W  controller read data, valid when busy falls after a read.
o_running  out  1  high from start accepted until DONE.
o_finished  out  1  high in DONE.
o_success  out  1  valid when o_finished: error count == 0 (and no timeout).
o_err_count  out  ERR_W  mismatches, saturating at all-ones.
o_first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
o_state  out  4  state encoding, for the debug display.

Behaviour:
- Reset (async, rstn_i low): all outputs 0, state IDLE, latched mode/seed 0.
  - Reset mid-transaction drops o_stb immediately.
  - No controller cleanup is attempted.
- States and encodings:
  - IDLE=0, WAIT_RDY=1, WR_REQ=2, WR_ACK=3, WR_WAIT=4, RD_REQ=5, RD_ACK=6, RD_WAIT=7, CHECK=8, DONE=9.
- IDLE/DONE:
  - i_start=1 latches i_mode and i_seed.
  - Sets index=0, clears o_err_count, o_first_err_addr, o_finished and o_success.
  - Sets o_running=1 and goes to WAIT_RDY.
- WAIT_RDY: when i_busy=0, load pattern generator from seed and go to WR_REQ.
- WR_REQ: drive o_addr, o_din=pattern(index), o_we=1, o_stb=1; go to WR_ACK.
- WR_ACK: hold stb/we/addr/din until i_busy=1, then drop o_stb and o_we; go to WR_WAIT.
- WR_WAIT: when i_busy=0:
  - If index==NUM_WORDS-1: index=0, reload generator, go to RD_REQ.
  - Otherwise: index++, advance generator, go to WR_REQ.
- RD_REQ: o_we=0, o_stb=1, o_addr for index; go to RD_ACK.
- RD_ACK: on i_busy=1 drop o_stb; go to RD_WAIT.
- RD_WAIT: when i_busy=0, register i_dout and go to CHECK.
- CHECK: compare the registered data with pattern(index).
  - On mismatch, increment o_err_count (saturating); if it was 0, load o_first_err_addr.
  - If index==NUM_WORDS-1, go to DONE with o_running=0, o_finished=1, o_success=(count==0).
  - Otherwise index++, advance generator, go to RD_REQ.
- Address: addr(index) = START_ADDR + index*ADDR_STEP, truncated to ADDR_W; kept as an accumulator, with no multiplier.
- Patterns:
  - Mode 0: seed.
  - Mode 1: addr[DATA_W-1:0].
  - Mode 2: 1 rotated left by (index mod DATA_W).
  - Mode 3: 16-bit Fibonacci LFSR, taps 16,14,13,11, shift left, feedback into bit 0. Data = low DATA_W bits. Seed bits zero-extended; an all-zero seed is replaced by 1.
- Write and read phases regenerate the identical sequence from the latched seed.
- i_start while running is ignored.
- i_mode/i_seed changes after start have no effect.
- i_busy already high in WR_REQ/RD_REQ: the strobe is still issued, and completion is the next observed 1->0 after acknowledgement.

Optional Feature:
PSRAM_TESTER_TIMEOUT_EN:
- Defined:
  - A 24-bit watchdog clears on every state change.
  - If any ACK or WAIT state persists 2^20 cycles: drop o_stb/o_we, go to DONE with o_success=0, and set extra output o_timeout=1 (cleared at the next start).
- Undefined: no watchdog, no o_timeout port; the block waits indefinitely.

Test Plan:
- NUM_WORDS=4, mode 0, seed 16'h8765, ideal model (busy 3 cycles after stb) -> 4 writes of 8765 at 0..3, 4 reads; o_finished=1, o_success=1, o_err_count=0.
- Mode 1, START_ADDR=24'hFFFFFE, ADDR_STEP=1, NUM_WORDS=4 -> addresses FFFFFE, FFFFFF, 000000, 000001 with data FFFE, FFFF, 0000, 0001; pass.
- Mode 3, seed 0, NUM_WORDS=8 -> first written word 0001, second 0002; read sequence identical; pass.
- Model flips bit 0 at address 5, NUM_WORDS=16, mode 2 -> o_err_count=1, o_first_err_addr=5, o_success=0.
- Assert rstn_i low during RD_ACK -> o_stb=0 and all status 0 in the same cycle. After release, i_start runs a clean full pass.
- With PSRAM_TESTER_TIMEOUT_EN, model never raises busy -> after 2^20 cycles: DONE, o_timeout=1, o_success=0, o_stb=0.

Source files
------------

// File: rtl/psram_pattern_tester.sv
// PSRAM pattern tester: writes a pattern over a word range, reads back, counts mismatches.
// Optional watchdog/o_timeout port enabled by defining PSRAM_TESTER_TIMEOUT_EN.
module psram_pattern_tester #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned ERR_W = 16
) (
  input  logic              clk_100mhz,
  input  logic              rstn_i,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_seed,
  output logic              o_stb,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_din,
  input  logic              i_busy,
  input  logic [DATA_W-1:0] i_dout,
  output logic              o_running,
  output logic              o_finished,
  output logic              o_success,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr,
`ifdef PSRAM_TESTER_TIMEOUT_EN
  output logic              o_timeout,
`endif
  output logic [3:0]        o_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WAIT_RDY = 4'd1,
    WR_REQ   = 4'd2,
    WR_ACK   = 4'd3,
    WR_WAIT  = 4'd4,
    RD_REQ   = 4'd5,
    RD_ACK   = 4'd6,
    RD_WAIT  = 4'd7,
    CHECK    = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t state, nxt;

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] walk;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] pat;
  logic              last;
  logic              mismatch;
  logic              lfsr_fb;
  logic              to_hit;

  assign last     = (idx == LAST);
  assign mismatch = (rd_q != pat);
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    pat = seed_q;
    unique case (mode_q)
      2'd0: pat = seed_q;
      2'd1: pat = addr_q[DATA_W-1:0];
      2'd2: pat = walk;
      2'd3: pat = lfsr[DATA_W-1:0];
      default: pat = seed_q;
    endcase
  end

`ifdef PSRAM_TESTER_TIMEOUT_EN
  logic [23:0] wd;
  logic        watched;

  assign watched = (state == WAIT_RDY) || (state == WR_ACK) ||
                   (state == WR_WAIT) || (state == RD_ACK) ||
                   (state == RD_WAIT);
  assign to_hit  = watched && (wd == 24'(20'hFFFFF));

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) wd <= '0;
    else if (state != nxt) wd <= '0;
    else if (watched) wd <= wd + 24'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt   = state;
    o_stb = 1'b0;
    o_we  = 1'b0;
    unique case (state)
      IDLE, DONE: if (i_start) nxt = WAIT_RDY;
      WAIT_RDY:   if (!i_busy) nxt = WR_REQ;
      WR_REQ: begin
        o_stb = 1'b1;
        o_we  = 1'b1;
        nxt   = WR_ACK;
      end
      WR_ACK: begin
        o_stb = 1'b1;
        o_we  = 1'b1;
        if (i_busy) nxt = WR_WAIT;
      end
      WR_WAIT: if (!i_busy) nxt = last ? RD_REQ : WR_REQ;
      RD_REQ: begin
        o_stb = 1'b1;
        nxt   = RD_ACK;
      end
      RD_ACK: begin
        o_stb = 1'b1;
        if (i_busy) nxt = RD_WAIT;
      end
      RD_WAIT: if (!i_busy) nxt = CHECK;
      CHECK:   nxt = last ? DONE : RD_REQ;
      default: nxt = IDLE;
    endcase
    if (to_hit) nxt = DONE;
  end

  assign o_addr  = addr_q;
  assign o_din   = o_we ? pat : '0;
  assign o_state = state;

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      idx              <= '0;
      addr_q           <= '0;
      mode_q           <= '0;
      seed_q           <= '0;
      lfsr             <= '0;
      walk             <= '0;
      rd_q             <= '0;
      o_running        <= 1'b0;
      o_finished       <= 1'b0;
      o_success        <= 1'b0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
`ifdef PSRAM_TESTER_TIMEOUT_EN
      o_timeout        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: if (i_start) begin
          mode_q           <= i_mode;
          seed_q           <= i_seed;
          idx              <= '0;
          addr_q           <= START_ADDR;
          o_err_count      <= '0;
          o_first_err_addr <= '0;
          o_finished       <= 1'b0;
          o_success        <= 1'b0;
          o_running        <= 1'b1;
`ifdef PSRAM_TESTER_TIMEOUT_EN
          o_timeout        <= 1'b0;
`endif
        end
        WAIT_RDY: if (!i_busy) begin
          lfsr <= (seed_q == '0) ? 16'd1 : 16'(seed_q);
          walk <= DATA_W'(1);
        end
        WR_WAIT: if (!i_busy) begin
          if (last) begin
            idx    <= '0;
            addr_q <= START_ADDR;
            lfsr   <= (seed_q == '0) ? 16'd1 : 16'(seed_q);
            walk   <= DATA_W'(1);
          end else begin
            idx    <= idx + IDX_W'(1);
            addr_q <= addr_q + STEP;
            lfsr   <= {lfsr[14:0], lfsr_fb};
            walk   <= {walk[DATA_W-2:0], walk[DATA_W-1]};
          end
        end
        RD_WAIT: if (!i_busy) rd_q <= i_dout;
        CHECK: begin
          if (mismatch) begin
            if (o_err_count != '1) o_err_count <= o_err_count + ERR_W'(1);
            if (o_err_count == '0) o_first_err_addr <= addr_q;
          end
          if (last) begin
            o_running  <= 1'b0;
            o_finished <= 1'b1;
            o_success  <= (o_err_count == '0) && !mismatch;
          end else begin
            idx    <= idx + IDX_W'(1);
            addr_q <= addr_q + STEP;
            lfsr   <= {lfsr[14:0], lfsr_fb};
            walk   <= {walk[DATA_W-2:0], walk[DATA_W-1]};
          end
        end
        default: ;
      endcase
`ifdef PSRAM_TESTER_TIMEOUT_EN
      if (to_hit) begin
        o_running  <= 1'b0;
        o_finished <= 1'b1;
        o_success  <= 1'b0;
        o_timeout  <= 1'b1;
      end
`endif
    end
  end

endmodule
